// File: rtl/booth_mul4.sv
// ---------------------------------------------------------------------------
// booth_mul4
//
// Sequential signed 4x4 radix-2 Booth multiplier producing an 8-bit
// two's-complement product. The add/sub step is not done here. Each CALC
// cycle this block drives an external 4-bit adder/subtractor through
// o_as_a/o_as_b/o_as_m. It takes that stage's sum and overflow back on
// i_as_sum/i_as_v, then shifts the result into the {A,Q,q_1} chain.
//
// Optional feature macro: BOOTH_ZERO_SKIP_EN
//   When defined, a zero operand at start completes the multiply without
//   entering CALC. The product is 0 and done pulses one cycle after start.
//   When undefined, zero operands take the normal four-iteration path.
//
// Ports
//   clk        in   1  clock, rising-edge
//   rst        in   1  asynchronous active-high reset
//   i_start    in   1  start request, honoured only while idle
//   i_a        in   4  signed multiplicand, captured on accepted start
//   i_b        in   4  signed multiplier, captured on accepted start
//   o_busy     out  1  high while iterating
//   o_done     out  1  one-cycle pulse when o_product is updated
//   o_product  out  8  signed product, held until the next completion
//   o_as_a     out  4  add/sub operand A (accumulator)
//   o_as_b     out  4  add/sub operand B (multiplicand)
//   o_as_m     out  1  add/sub mode, 1 = subtract (A - M)
//   i_as_sum   in   4  add/sub result
//   i_as_v     in   1  add/sub signed overflow
// ---------------------------------------------------------------------------
module booth_mul4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_product,
  output logic [3:0] o_as_a,
  output logic [3:0] o_as_b,
  output logic       o_as_m,
  input  logic [3:0] i_as_sum,
  input  logic       i_as_v
);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t     r_state;
  logic [3:0] r_acc;
  logic [3:0] r_q;
  logic       r_q1;
  logic [3:0] r_m;
  logic [2:0] r_cnt;
  logic [7:0] r_product;
  logic       r_done;

  logic       w_useSum;
  logic [3:0] w_r;
  logic       w_s;
  logic [3:0] w_nextAcc;
  logic [3:0] w_nextQ;

  // The external stage always sees the accumulator and the multiplicand.
  // The stage subtracts only for the Booth pair 10. For pair 01 it adds.
  // For pairs 00 and 11 its result is not used.
  assign o_as_a    = r_acc;
  assign o_as_b    = r_m;
  assign o_as_m    = r_q[0] & ~r_q1;
  assign o_busy    = (r_state == CALC);
  assign o_done    = r_done;
  assign o_product = r_product;

  // Build one Booth step: choose the add/sub result or the plain
  // accumulator, then form the arithmetic-right-shifted A and Q.
  // The sign shifted into A comes from the true 5-bit result. When the
  // stage overflows, the sum's top bit is wrong, and xor-ing it with the
  // overflow flag restores the sign. This only happens when M = -8.
  always_comb begin
    w_useSum  = r_q[0] ^ r_q1;
    w_r       = w_useSum ? i_as_sum : r_acc;
    w_s       = w_useSum ? (i_as_sum[3] ^ i_as_v) : r_acc[3];
    w_nextAcc = {w_s, w_r[3:1]};
    w_nextQ   = {w_r[0], r_q[3:1]};
  end

  // Control FSM and datapath registers.
  // IDLE loads the operands when start arrives.
  // CALC runs one shift per clock. On the fourth shift, the post-shift
  // {A,Q} is written to the product, done is raised for one cycle, and
  // the FSM returns to IDLE. A start arriving in that done cycle is
  // therefore accepted straight away.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= 4'd0;
      r_q       <= 4'd0;
      r_q1      <= 1'b0;
      r_m       <= 4'd0;
      r_cnt     <= 3'd0;
      r_product <= 8'h00;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
`ifdef BOOTH_ZERO_SKIP_EN
            if ((i_a == 4'd0) || (i_b == 4'd0)) begin
              r_product <= 8'h00;
              r_done    <= 1'b1;
            end else begin
              r_m     <= i_a;
              r_q     <= i_b;
              r_acc   <= 4'd0;
              r_q1    <= 1'b0;
              r_cnt   <= 3'd4;
              r_state <= CALC;
            end
`else
            r_m     <= i_a;
            r_q     <= i_b;
            r_acc   <= 4'd0;
            r_q1    <= 1'b0;
            r_cnt   <= 3'd4;
            r_state <= CALC;
`endif
          end
        end
        CALC: begin
          r_acc <= w_nextAcc;
          r_q   <= w_nextQ;
          r_q1  <= r_q[0];
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            r_product <= {w_nextAcc, w_nextQ};
            r_done    <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul4.sv
// ---------------------------------------------------------------------------
// tb_booth_mul4
//
// Directed bench for booth_mul4. It contains a behavioural model of the
// downstream 4-bit adder/subtractor that feeds i_as_sum/i_as_v back.
// Expected products are hand-computed signed results.
// If the bench is compiled with BOOTH_ZERO_SKIP_EN, the zero-operand
// step expects the shortcut path instead of the normal path.
// ---------------------------------------------------------------------------
module tb_booth_mul4;

  logic       clk;
  logic       rst;
  logic       i_start;
  logic [3:0] i_a;
  logic [3:0] i_b;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_product;
  logic [3:0] o_as_a;
  logic [3:0] o_as_b;
  logic       o_as_m;
  logic [3:0] i_as_sum;
  logic       i_as_v;

  int total = 0;
  int bad   = 0;

  booth_mul4 dut (
    .clk       (clk),
    .rst       (rst),
    .i_start   (i_start),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_product (o_product),
    .o_as_a    (o_as_a),
    .o_as_b    (o_as_b),
    .o_as_m    (o_as_m),
    .i_as_sum  (i_as_sum),
    .i_as_v    (i_as_v)
  );

  // 100 MHz style clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the 4-bit adder/subtractor stage, including signed overflow.
  always_comb begin
    i_as_sum = o_as_m ? (o_as_a - o_as_b) : (o_as_a + o_as_b);
    if (o_as_m)
      i_as_v = (o_as_a[3] != o_as_b[3]) && (i_as_sum[3] != o_as_a[3]);
    else
      i_as_v = (o_as_a[3] == o_as_b[3]) && (i_as_sum[3] != o_as_a[3]);
  end

  // One comparison: count it, and count and report it if it fails.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a start request and let the next edge accept it.
  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
    i_a     = a;
    i_b     = b;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  // Count edges after acceptance until done is seen. The wait is bounded.
  task automatic waitDone(output int n);
    n = 0;
    while (o_done !== 1'b1 && n < 12) begin
      step();
      n++;
    end
  endtask

  // One full multiply. Check busy just after acceptance, then latency and
  // product. Stop in the done cycle so a caller can start back-to-back.
  task automatic runOp(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] expProd, input int expLat,
                       input logic expBusy);
    int n;
    applyStimulus(a, b);
    checkOutput({tag, "_busy"}, {7'd0, o_busy}, {7'd0, expBusy});
    waitDone(n);
    checkOutput({tag, "_latency"}, 8'(n), 8'(expLat));
    checkOutput({tag, "_product"}, o_product, expProd);
  endtask

  initial begin
    int   n;
    logic sawDone;

    rst     = 1'b1;
    i_start = 1'b0;
    i_a     = 4'd0;
    i_b     = 4'd0;
    repeat (2) step();
    checkOutput("reset_busy", {7'd0, o_busy}, 8'h00);
    checkOutput("reset_done", {7'd0, o_done}, 8'h00);
    checkOutput("reset_product", o_product, 8'h00);
    rst = 1'b0;
    step();

    // 3 * 5 = 15, then check that done is a single cycle and the product holds.
    runOp("mul_3x5", 4'd3, 4'd5, 8'h0F, 4, 1'b1);
    step();
    checkOutput("mul_3x5_donePulse", {7'd0, o_done}, 8'h00);
    checkOutput("mul_3x5_hold", o_product, 8'h0F);

    // -8 * -8 = 64; this needs the overflow sign correction.
    runOp("mul_m8xm8", 4'h8, 4'h8, 8'h40, 4, 1'b1);
    step();

    // -8 * 7 = -56, then back-to-back 7 * -1 = -7 and 2 * -3 = -6.
    // Each op starts in the previous done cycle, so the dones are 5 cycles apart.
    runOp("mul_m8x7", 4'h8, 4'h7, 8'hC8, 4, 1'b1);
    runOp("mul_7xm1", 4'h7, 4'hF, 8'hF9, 4, 1'b1);
    runOp("mul_2xm3", 4'h2, 4'hD, 8'hFA, 4, 1'b1);
    step();
    checkOutput("b2b_donePulse", {7'd0, o_done}, 8'h00);

    // Hold start high through busy with new operands.
    // The first result must be 3 * 5, and -1 * 2 is accepted only in the done cycle.
    i_a     = 4'd3;
    i_b     = 4'd5;
    i_start = 1'b1;
    step();
    i_a = 4'hF;
    i_b = 4'h2;
    waitDone(n);
    checkOutput("held_first_latency", 8'(n), 8'd4);
    checkOutput("held_first_product", o_product, 8'h0F);
    step();
    i_start = 1'b0;
    checkOutput("held_second_busy", {7'd0, o_busy}, 8'h01);
    waitDone(n);
    checkOutput("held_second_latency", 8'(n), 8'd4);
    checkOutput("held_second_product", o_product, 8'hFE);
    step();

    // A zero operand gives product 0, with the shortcut path when enabled.
`ifdef BOOTH_ZERO_SKIP_EN
    runOp("zero_0x5", 4'd0, 4'd5, 8'h00, 0, 1'b0);
`else
    runOp("zero_0x5", 4'd0, 4'd5, 8'h00, 4, 1'b1);
`endif
    step();
    checkOutput("zero_donePulse", {7'd0, o_done}, 8'h00);

    // Reset during the second CALC cycle aborts at once, and no done follows.
    runOp("pre_abort", 4'd7, 4'd7, 8'h31, 4, 1'b1);
    applyStimulus(4'd7, 4'd6);
    step();
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", {7'd0, o_busy}, 8'h00);
    checkOutput("abort_done", {7'd0, o_done}, 8'h00);
    checkOutput("abort_product", o_product, 8'h00);
    step();
    rst     = 1'b0;
    sawDone = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (o_done === 1'b1) sawDone = 1'b1;
    end
    checkOutput("abort_noLateDone", {7'd0, sawDone}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
